// File: rtl/scan_sampler.sv
// scan_sampler: steps an analog-mux address across CH_NUM channels, waits a
// programmable settle time on each, and pushes the ADC value into an on-chip
// FIFO. Each frame is closed by two terminator words. When the FIFO is full
// the scanner stalls in place, so no sample is ever dropped or overwritten.
module scan_sampler #(
  parameter int                CH_NUM         = 32,
  parameter int                ADDR_W         = 5,
  parameter int                DATA_W         = 8,
  parameter int                SETTLE_CYC     = 500000,
  parameter int                SCANS          = 10,
  parameter int                TERM_EACH_SCAN = 0,
  parameter logic [DATA_W-1:0] TERM0          = 'h0d,
  parameter logic [DATA_W-1:0] TERM1          = 'h0a,
  parameter int                FIFO_AW        = 12
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              stop,
  input  logic [DATA_W-1:0] adc_data,
  output logic [ADDR_W-1:0] addr,
  output logic              busy,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              empty,
  output logic              full,
  output logic [FIFO_AW:0]  usedw
);

  localparam int DEPTH  = 1 << FIFO_AW;
  localparam int CNT_W  = $clog2(SETTLE_CYC + 1);
  localparam int SCAN_W = $clog2(SCANS + 2);

  localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [ADDR_W-1:0] CH_LAST     = ADDR_W'(CH_NUM - 1);
  localparam logic [SCAN_W-1:0] SCAN_LAST   = SCAN_W'(SCANS - 1);
  localparam logic [SCAN_W-1:0] SCAN_END    = SCAN_W'(SCANS);
  localparam logic [FIFO_AW:0]  FULL_LVL    = (FIFO_AW + 1)'(DEPTH);
  localparam bit                CONTINUOUS  = (SCANS == 0);
  localparam bit                TERM_EVERY  = (TERM_EACH_SCAN != 0);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_TERM0,
    ST_TERM1
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [CNT_W-1:0]    settle_cnt_q, settle_cnt_d;
  logic [SCAN_W-1:0]   scan_cnt_q, scan_cnt_d;
  logic [SCAN_W-1:0]   scan_inc;
  logic                start_q;
  logic                stop_pend_q, stop_pend_d;
  logic                start_edge;
  logic                last_scan;
  logic                run_done;

  logic                wr_en;
  logic [DATA_W-1:0]   wr_data;
  logic                rd_fire;
  logic [FIFO_AW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [FIFO_AW:0]    usedw_q;
  logic [DATA_W-1:0]   rd_data_q;
  logic [DATA_W-1:0]   mem [DEPTH];

  assign start_edge = start & ~start_q;
  assign scan_inc   = (scan_cnt_q == '1) ? scan_cnt_q : scan_cnt_q + SCAN_W'(1);
  assign last_scan  = !CONTINUOUS && (scan_cnt_q == SCAN_LAST);
  // Evaluated in TERM1, after the scan count has already been bumped.
  assign run_done   = (!CONTINUOUS && (scan_cnt_q == SCAN_END)) || stop_pend_q;

  assign busy    = (state_q != ST_IDLE);
  assign addr    = addr_q;
  assign empty   = (usedw_q == '0);
  assign full    = (usedw_q == FULL_LVL);
  assign usedw   = usedw_q;
  assign rd_data = rd_data_q;
  assign rd_fire = rd_en && !empty;

  // Abort requests are latched for the rest of the run and dropped in IDLE.
  assign stop_pend_d = (state_q == ST_IDLE) ? 1'b0 : (stop_pend_q | stop);

  // Next-state, address, counters and FIFO write request.
  always_comb begin
    // NOTE: every signal gets a default here so no path leaves it unassigned
    // and no latch is inferred.
    state_d      = state_q;
    addr_d       = addr_q;
    settle_cnt_d = '0;
    scan_cnt_d   = scan_cnt_q;
    wr_en        = 1'b0;
    wr_data      = adc_data;

    unique case (state_q)
      ST_IDLE: begin
        addr_d     = '0;
        scan_cnt_d = '0;
        if (start_edge) state_d = ST_SETTLE;
      end

      ST_SETTLE: begin
        if (stop_pend_q) begin
          state_d = ST_TERM0;
        end else if (settle_cnt_q == SETTLE_LAST) begin
          state_d = ST_SAMPLE;
        end else begin
          settle_cnt_d = settle_cnt_q + CNT_W'(1);
        end
      end

      ST_SAMPLE: begin
        // A full FIFO stalls the scanner on the current channel.
        if (!full) begin
          wr_en = 1'b1;
          if (addr_q != CH_LAST && !stop_pend_q) begin
            addr_d  = addr_q + ADDR_W'(1);
            state_d = ST_SETTLE;
          end else if (addr_q == CH_LAST) begin
            scan_cnt_d = scan_inc;
            if (last_scan || stop_pend_q || TERM_EVERY) begin
              state_d = ST_TERM0;
            end else begin
              addr_d  = '0;
              state_d = ST_SETTLE;
            end
          end else begin
            state_d = ST_TERM0;
          end
        end
      end

      ST_TERM0: begin
        if (!full) begin
          wr_en   = 1'b1;
          wr_data = TERM0;
          state_d = ST_TERM1;
        end
      end

      ST_TERM1: begin
        if (!full) begin
          wr_en   = 1'b1;
          wr_data = TERM1;
          addr_d  = '0;
          state_d = run_done ? ST_IDLE : ST_SETTLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Scanner state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      settle_cnt_q <= '0;
      scan_cnt_q   <= '0;
      stop_pend_q  <= 1'b0;
      // Resetting high means a start held through reset release is not an edge.
      start_q      <= 1'b1;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      state_q      <= state_d;
      addr_q       <= addr_d;
      settle_cnt_q <= settle_cnt_d;
      scan_cnt_q   <= scan_cnt_d;
      stop_pend_q  <= stop_pend_d;
      start_q      <= start;
    end
  end

  // FIFO storage array.
  always_ff @(posedge clk) begin
    // NOTE: the storage array has no reset; occupancy alone defines which
    // words are valid, so clearing pointers and count discards the contents.
    if (wr_en) mem[wr_ptr_q] <= wr_data;
  end

  // FIFO pointers, occupancy and registered read data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      usedw_q   <= '0;
      rd_data_q <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + FIFO_AW'(1);
      if (rd_fire) begin
        rd_ptr_q  <= rd_ptr_q + FIFO_AW'(1);
        rd_data_q <= mem[rd_ptr_q];
      end
      usedw_q <= usedw_q + (FIFO_AW + 1)'(wr_en) - (FIFO_AW + 1)'(rd_fire);
    end
  end

endmodule

// File: tb/tb_scan_sampler.sv
// Directed bench for scan_sampler. Four instances cover the two-scan run,
// per-scan terminators, back-pressure with a 4-word FIFO, and continuous mode
// with stop; FIFO corner cases and reset abort reuse the two-scan instance.
module tb_scan_sampler;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start_v   [4];
  logic       stop_v    [4];
  logic       rd_en_v   [4];
  logic [4:0] addr_v    [4];
  logic [7:0] adc_v     [4];
  logic       busy_v    [4];
  logic       empty_v   [4];
  logic       full_v    [4];
  logic [7:0] rd_data_v [4];
  logic [4:0] usedw_a, usedw_b, usedw_d;
  logic [2:0] usedw_c;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [7:0] EXP_TWO  [10] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10,
                                           8'h11, 8'h12, 8'h13, 8'h0d, 8'h0a};
  localparam logic [7:0] EXP_EACH [12] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h0d, 8'h0a,
                                           8'h10, 8'h11, 8'h12, 8'h13, 8'h0d, 8'h0a};
  localparam logic [7:0] EXP_STOP [12] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10, 8'h11,
                                           8'h12, 8'h13, 8'h10, 8'h11, 8'h0d, 8'h0a};

  always #5 clk = ~clk;

  // ADC model: each channel reads as its address plus 0x10.
  assign adc_v[0] = {3'b000, addr_v[0]} + 8'h10;
  assign adc_v[1] = {3'b000, addr_v[1]} + 8'h10;
  assign adc_v[2] = {3'b000, addr_v[2]} + 8'h10;
  assign adc_v[3] = {3'b000, addr_v[3]} + 8'h10;

  scan_sampler #(.CH_NUM(4), .ADDR_W(5), .DATA_W(8), .SETTLE_CYC(3), .SCANS(2),
                 .TERM_EACH_SCAN(0), .FIFO_AW(4)) u_two (
    .clk(clk), .reset_n(reset_n), .start(start_v[0]), .stop(stop_v[0]),
    .adc_data(adc_v[0]), .addr(addr_v[0]), .busy(busy_v[0]), .rd_en(rd_en_v[0]),
    .rd_data(rd_data_v[0]), .empty(empty_v[0]), .full(full_v[0]), .usedw(usedw_a));

  scan_sampler #(.CH_NUM(4), .ADDR_W(5), .DATA_W(8), .SETTLE_CYC(3), .SCANS(2),
                 .TERM_EACH_SCAN(1), .FIFO_AW(4)) u_each (
    .clk(clk), .reset_n(reset_n), .start(start_v[1]), .stop(stop_v[1]),
    .adc_data(adc_v[1]), .addr(addr_v[1]), .busy(busy_v[1]), .rd_en(rd_en_v[1]),
    .rd_data(rd_data_v[1]), .empty(empty_v[1]), .full(full_v[1]), .usedw(usedw_b));

  scan_sampler #(.CH_NUM(4), .ADDR_W(5), .DATA_W(8), .SETTLE_CYC(3), .SCANS(2),
                 .TERM_EACH_SCAN(0), .FIFO_AW(2)) u_bp (
    .clk(clk), .reset_n(reset_n), .start(start_v[2]), .stop(stop_v[2]),
    .adc_data(adc_v[2]), .addr(addr_v[2]), .busy(busy_v[2]), .rd_en(rd_en_v[2]),
    .rd_data(rd_data_v[2]), .empty(empty_v[2]), .full(full_v[2]), .usedw(usedw_c));

  scan_sampler #(.CH_NUM(4), .ADDR_W(5), .DATA_W(8), .SETTLE_CYC(3), .SCANS(0),
                 .TERM_EACH_SCAN(0), .FIFO_AW(4)) u_cont (
    .clk(clk), .reset_n(reset_n), .start(start_v[3]), .stop(stop_v[3]),
    .adc_data(adc_v[3]), .addr(addr_v[3]), .busy(busy_v[3]), .rd_en(rd_en_v[3]),
    .rd_data(rd_data_v[3]), .empty(empty_v[3]), .full(full_v[3]), .usedw(usedw_d));

  function automatic int usedw_of(input int i);
    case (i)
      0:       return int'(usedw_a);
      1:       return int'(usedw_b);
      2:       return int'(usedw_c);
      default: return int'(usedw_d);
    endcase
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start(input int i);
    start_v[i] = 1'b1;
    step(1);
    start_v[i] = 1'b0;
  endtask

  task automatic read_word(input int i, output logic [7:0] d);
    rd_en_v[i] = 1'b1;
    step(1);
    rd_en_v[i] = 1'b0;
    d = rd_data_v[i];
  endtask

  task automatic wait_idle(input int i, input int budget);
    for (int c = 0; c < budget && busy_v[i] === 1'b1; c++) step(1);
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      start_v[i] = 1'b0;
      stop_v[i]  = 1'b0;
      rd_en_v[i] = 1'b0;
    end
    step(2);
    reset_n = 1'b1;
    step(1);
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (busy_v[i] !== 1'b0) begin
        n_fail++; $display("FAIL reset_busy[%0d]: got %b, expected 0", i, busy_v[i]);
      end
      n_tests++;
      if (empty_v[i] !== 1'b1 || full_v[i] !== 1'b0) begin
        n_fail++; $display("FAIL reset_flags[%0d]: empty %b full %b, expected 1 0", i, empty_v[i], full_v[i]);
      end
      n_tests++;
      if (addr_v[i] !== 5'd0 || rd_data_v[i] !== 8'h00 || usedw_of(i) != 0) begin
        n_fail++; $display("FAIL reset_regs[%0d]: addr %0h rd_data %0h usedw %0d, expected 0 0 0", i, addr_v[i], rd_data_v[i], usedw_of(i));
      end
    end
  endtask

  task automatic test_two_scan;
    logic [7:0] d;
    pulse_start(0);
    step(3);
    n_tests++;
    if (empty_v[0] !== 1'b1 || busy_v[0] !== 1'b1 || addr_v[0] !== 5'd0) begin
      n_fail++; $display("FAIL two_pre_write: empty %b busy %b addr %0d, expected 1 1 0", empty_v[0], busy_v[0], addr_v[0]);
    end
    step(1);
    n_tests++;
    if (empty_v[0] !== 1'b0 || usedw_of(0) != 1 || addr_v[0] !== 5'd1) begin
      n_fail++; $display("FAIL two_first_write: empty %b usedw %0d addr %0d, expected 0 1 1", empty_v[0], usedw_of(0), addr_v[0]);
    end
    wait_idle(0, 200);
    n_tests++;
    if (busy_v[0] !== 1'b0 || usedw_of(0) != 10) begin
      n_fail++; $display("FAIL two_done: busy %b usedw %0d, expected 0 10", busy_v[0], usedw_of(0));
    end
    for (int k = 0; k < 10; k++) begin
      read_word(0, d);
      n_tests++;
      if (d !== EXP_TWO[k]) begin
        n_fail++; $display("FAIL two_word[%0d]: got %0h, expected %0h", k, d, EXP_TWO[k]);
      end
    end
  endtask

  task automatic test_empty_read;
    rd_en_v[0] = 1'b1;
    step(1);
    rd_en_v[0] = 1'b0;
    n_tests++;
    if (rd_data_v[0] !== 8'h0a || usedw_of(0) != 0 || empty_v[0] !== 1'b1) begin
      n_fail++; $display("FAIL empty_read: rd_data %0h usedw %0d empty %b, expected 0a 0 1", rd_data_v[0], usedw_of(0), empty_v[0]);
    end
  endtask

  task automatic test_same_cycle_rw;
    logic [7:0] d;
    pulse_start(0);
    for (int c = 0; c < 100 && usedw_of(0) != 2; c++) step(1);
    n_tests++;
    if (usedw_of(0) != 2) begin
      n_fail++; $display("FAIL rw_reach2: usedw %0d, expected 2", usedw_of(0));
    end
    // The next sample is written three settle cycles plus one sample cycle later.
    step(3);
    rd_en_v[0] = 1'b1;
    step(1);
    rd_en_v[0] = 1'b0;
    n_tests++;
    if (usedw_of(0) != 2 || rd_data_v[0] !== 8'h10) begin
      n_fail++; $display("FAIL rw_same_cycle: usedw %0d rd_data %0h, expected 2 10", usedw_of(0), rd_data_v[0]);
    end
    wait_idle(0, 200);
    n_tests++;
    if (busy_v[0] !== 1'b0 || usedw_of(0) != 9) begin
      n_fail++; $display("FAIL rw_done: busy %b usedw %0d, expected 0 9", busy_v[0], usedw_of(0));
    end
    for (int k = 1; k < 10; k++) begin
      read_word(0, d);
      n_tests++;
      if (d !== EXP_TWO[k]) begin
        n_fail++; $display("FAIL rw_word[%0d]: got %0h, expected %0h", k, d, EXP_TWO[k]);
      end
    end
  endtask

  task automatic test_per_scan_term;
    logic [7:0] d;
    pulse_start(1);
    wait_idle(1, 300);
    n_tests++;
    if (busy_v[1] !== 1'b0 || usedw_of(1) != 12) begin
      n_fail++; $display("FAIL each_done: busy %b usedw %0d, expected 0 12", busy_v[1], usedw_of(1));
    end
    for (int k = 0; k < 12; k++) begin
      read_word(1, d);
      n_tests++;
      if (d !== EXP_EACH[k]) begin
        n_fail++; $display("FAIL each_word[%0d]: got %0h, expected %0h", k, d, EXP_EACH[k]);
      end
    end
  endtask

  task automatic test_back_pressure;
    logic [7:0] d;
    int         idx;
    pulse_start(2);
    step(40);
    n_tests++;
    if (full_v[2] !== 1'b1 || usedw_of(2) != 4 || busy_v[2] !== 1'b1 || addr_v[2] !== 5'd0) begin
      n_fail++; $display("FAIL bp_stall: full %b usedw %0d busy %b addr %0d, expected 1 4 1 0", full_v[2], usedw_of(2), busy_v[2], addr_v[2]);
    end
    read_word(2, d);
    n_tests++;
    if (d !== 8'h10 || usedw_of(2) != 3 || full_v[2] !== 1'b0) begin
      n_fail++; $display("FAIL bp_drain1: word %0h usedw %0d full %b, expected 10 3 0", d, usedw_of(2), full_v[2]);
    end
    step(1);
    n_tests++;
    if (usedw_of(2) != 4 || full_v[2] !== 1'b1) begin
      n_fail++; $display("FAIL bp_refill: usedw %0d full %b, expected 4 1", usedw_of(2), full_v[2]);
    end
    idx = 1;
    for (int c = 0; c < 600 && idx < 10; c++) begin
      if (empty_v[2] === 1'b0) begin
        read_word(2, d);
        n_tests++;
        if (d !== EXP_TWO[idx]) begin
          n_fail++; $display("FAIL bp_word[%0d]: got %0h, expected %0h", idx, d, EXP_TWO[idx]);
        end
        idx++;
      end else begin
        step(1);
      end
    end
    n_tests++;
    if (idx != 10) begin
      n_fail++; $display("FAIL bp_count: got %0d words, expected 10", idx);
    end
    wait_idle(2, 100);
    step(5);
    n_tests++;
    if (busy_v[2] !== 1'b0 || empty_v[2] !== 1'b1) begin
      n_fail++; $display("FAIL bp_end: busy %b empty %b, expected 0 1", busy_v[2], empty_v[2]);
    end
  endtask

  task automatic test_continuous_stop;
    logic [7:0] d;
    pulse_start(3);
    // Ten words means scan 3 channel 1 was just written and channel 2 settles.
    for (int c = 0; c < 200 && usedw_of(3) != 10; c++) step(1);
    n_tests++;
    if (usedw_of(3) != 10 || addr_v[3] !== 5'd2) begin
      n_fail++; $display("FAIL cont_reach: usedw %0d addr %0d, expected 10 2", usedw_of(3), addr_v[3]);
    end
    stop_v[3] = 1'b1;
    step(1);
    stop_v[3] = 1'b0;
    wait_idle(3, 100);
    n_tests++;
    if (busy_v[3] !== 1'b0 || addr_v[3] !== 5'd0 || usedw_of(3) != 12) begin
      n_fail++; $display("FAIL cont_stop: busy %b addr %0d usedw %0d, expected 0 0 12", busy_v[3], addr_v[3], usedw_of(3));
    end
    for (int k = 0; k < 12; k++) begin
      read_word(3, d);
      n_tests++;
      if (d !== EXP_STOP[k]) begin
        n_fail++; $display("FAIL cont_word[%0d]: got %0h, expected %0h", k, d, EXP_STOP[k]);
      end
    end
  endtask

  task automatic test_reset_abort;
    start_v[0] = 1'b1;
    step(1);
    for (int c = 0; c < 50 && usedw_of(0) != 1; c++) step(1);
    step(1);
    n_tests++;
    if (busy_v[0] !== 1'b1 || usedw_of(0) != 1) begin
      n_fail++; $display("FAIL abort_pre: busy %b usedw %0d, expected 1 1", busy_v[0], usedw_of(0));
    end
    reset_n = 1'b0;
    #2;
    n_tests++;
    if (busy_v[0] !== 1'b0 || empty_v[0] !== 1'b1 || usedw_of(0) != 0 || addr_v[0] !== 5'd0 || rd_data_v[0] !== 8'h00 || full_v[0] !== 1'b0) begin
      n_fail++; $display("FAIL abort_reset: busy %b empty %b usedw %0d addr %0d rd_data %0h full %b, expected 0 1 0 0 0 0",
                         busy_v[0], empty_v[0], usedw_of(0), addr_v[0], rd_data_v[0], full_v[0]);
    end
    step(2);
    reset_n = 1'b1;
    step(10);
    n_tests++;
    if (busy_v[0] !== 1'b0 || empty_v[0] !== 1'b1) begin
      n_fail++; $display("FAIL abort_held_start: busy %b empty %b, expected 0 1", busy_v[0], empty_v[0]);
    end
    start_v[0] = 1'b0;
    step(1);
    start_v[0] = 1'b1;
    step(1);
    start_v[0] = 1'b0;
    n_tests++;
    if (busy_v[0] !== 1'b1) begin
      n_fail++; $display("FAIL abort_restart: busy %b, expected 1", busy_v[0]);
    end
    wait_idle(0, 200);
    n_tests++;
    if (busy_v[0] !== 1'b0 || usedw_of(0) != 10) begin
      n_fail++; $display("FAIL abort_rerun: busy %b usedw %0d, expected 0 10", busy_v[0], usedw_of(0));
    end
  endtask

  initial begin
    test_reset;
    test_two_scan;
    test_empty_read;
    test_same_cycle_rw;
    test_per_scan_term;
    test_back_pressure;
    test_continuous_stop;
    test_reset_abort;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/scan_sampler.md
# scan_sampler

Parametrised multi-channel polling sampler with on-chip FIFO. It steps an analog-mux address across `CH_NUM` channels, waits a programmable settle time on each, and writes the ADC value into an internal FIFO. Each frame ends with two terminator words. It sits between the mux/ADC front end and the UART/host read-out logic. This generation adds width, depth and channel parametrisation, continuous mode, abort, per-scan framing and back-pressure stalling instead of silent overwrite.

## Interface
Parameters:
- `CH_NUM`, 32: channels per scan, 2..2^`ADDR_W`.
- `ADDR_W`, 5: width of `addr`.
- `DATA_W`, 8: sample and FIFO word width.
- `SETTLE_CYC`, 500000: settle cycles per channel, ≥1.
- `SCANS`, 10: full scans per run; 0 means continuous until `stop`.
- `TERM_EACH_SCAN`, 0: 1 means terminators after every scan; 0 means only at run end.
- `TERM0`, 'h0d: first terminator word.
- `TERM1`, 'h0a: second terminator word.
- `FIFO_AW`, 12: FIFO depth is 2^`FIFO_AW` words.

Ports:
- `clk` in 1: clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: a rising edge starts a run.
- `stop` in 1: abort request, level-sampled.
- `adc_data` in `DATA_W`: current ADC value for `addr`.
- `addr` out `ADDR_W`: mux channel address.
- `busy` out 1: high while state ≠ IDLE.
- `rd_en` in 1: FIFO read request.
- `rd_data` out `DATA_W`: registered FIFO read data.
- `empty` out 1: FIFO empty.
- `full` out 1: FIFO full.
- `usedw` out `FIFO_AW`+1: FIFO occupancy.

## Operation
- The clock domain is `clk`. `reset_n` is asynchronous, active-low.
- Reset values:
  - state IDLE; `addr`=0; `busy`=0; `empty`=1; `full`=0; `usedw`=0; `rd_data`=0.
  - All counters 0; stop-pending flag 0.
  - Start-edge register resets to 1, so a `start` held high through reset release does not trigger a run.
- Start edge: `start`=1 while the registered previous value is 0. Edges are ignored when `busy`=1.
- FSM states:
  - IDLE:
    - `addr`=0, scan count 0, stop-pending cleared.
    - On a start edge, go to SETTLE with the settle counter at 0.
  - SETTLE:
    - The counter increments each cycle. At `SETTLE_CYC`-1 go to SAMPLE.
    - If stop-pending is set, go directly to TERM0 (partial frame).
  - SAMPLE (write `adc_data`):
    - If `full`=1, hold the state with `addr` unchanged.
    - Otherwise write the word and take the first matching exit:
      1. `addr`≠`CH_NUM`-1 and stop-pending clear: `addr`+1, go to SETTLE.
      2. `addr`=`CH_NUM`-1: scan count +1, then go to TERM0 if this was the last scan (`SCANS`≠0 and count=`SCANS`-1), stop-pending is set, or `TERM_EACH_SCAN`=1. Otherwise set `addr`=0 and go to SETTLE.
      3. Stop-pending set (not the last channel): go to TERM0.
  - TERM0: if `full`=0, write `TERM0` and go to TERM1; otherwise hold.
  - TERM1: if `full`=0, write `TERM1`, then:
    - If the run is done (last scan reached, or stop-pending set), go to IDLE.
    - Otherwise set `addr`=0 and go to SETTLE.
- Stop-pending is set when `stop`=1 while `busy`=1.
- `addr` is stable for the entire SETTLE+SAMPLE dwell of a channel.
- Scan count saturates and is unused in continuous mode.
- FIFO:
  - Synchronous, single clock, non-show-ahead.
  - Write and read pointers are `FIFO_AW` bits and wrap modulo depth.
  - `usedw` = writes − reads.
  - `full` = (`usedw` = 2^`FIFO_AW`); `empty` = (`usedw` = 0).
  - `rd_en` with `empty`=1 is ignored: `rd_data` and `usedw` unchanged.
  - A simultaneous read and write with `empty`=0 leaves `usedw` unchanged.
  - The writer never writes when `full`=1, so no word is ever lost or overwritten.

## Timing
- Start-edge detect: 1 cycle.
  - Cycle k: edge sampled. Cycles k+1..k+`SETTLE_CYC`: SETTLE. Cycle k+`SETTLE_CYC`+1: SAMPLE.
  - `empty` falls at the end of cycle k+`SETTLE_CYC`+1.
- Channel period without stall: `SETTLE_CYC`+1 cycles. Each terminator adds 1 cycle. Each full-stall cycle adds 1 cycle.
- `adc_data` is captured on the edge that exits SAMPLE.
- `addr` changes on that same edge. `busy` falls on the edge that exits TERM1.
- Read: `rd_data` is valid the cycle after `rd_en`. `usedw`, `empty` and `full` update on the same edge as the access.
- Reset asserted mid-run: everything returns to reset values immediately and FIFO contents are discarded.

## Test plan
- Two-scan run:
  - Setup: `CH_NUM`=4, `SETTLE_CYC`=3, `SCANS`=2, `TERM_EACH_SCAN`=0, `adc_data`=`addr`+'h10.
  - Stimulus: start pulse.
  - Required response: FIFO reads 10 11 12 13 10 11 12 13 0d 0a. First word is written 5 cycles after the edge cycle. `busy` falls after 0a.
- Per-scan terminators: same setup with `TERM_EACH_SCAN`=1 → reads 10 11 12 13 0d 0a 10 11 12 13 0d 0a.
- Back-pressure:
  - Setup: `FIFO_AW`=2, `CH_NUM`=4, `SCANS`=2; no reads.
  - Required while not draining: `full`=1 after 4 words, FSM holds SAMPLE with `addr`=0.
  - Drain one word → a new 10 is written on the next cycle. Full drain yields the exact sequence with no gaps or duplicates.
- Continuous mode with stop:
  - Setup: `SCANS`=0, `CH_NUM`=4.
  - Stimulus: pulse `stop` during SETTLE of ch 2, scan 3.
  - Required response: the stream ends …10 11 0d 0a; the ch 2 sample is not written. State returns to IDLE with `addr`=0 and `busy`=0.
- Reset abort: assert `reset_n`=0 mid-SETTLE while `start` is held high.
  - Required during reset: outputs go to reset values and `empty`=1.
  - Required after release: no run until `start` falls and rises again.
- FIFO corner cases:
  - `rd_en` with empty → `usedw`=0, `rd_data` unchanged.
  - Read and write in the same cycle at `usedw`=2 → `usedw` stays 2.
  - 2^`FIFO_AW`+3 words through the FIFO (pointer wrap) → ordering preserved.
